register_bank: RTL and testbench

//  Parametrised bank of NUM_REGS general-purpose registers; successor to the single-register block.
//  One operation per cycle: clear / load / inc / dec / shift, applied to the register chosen by sel.

---
 rtl/register_bank_pkg.sv | 40 ++++
 rtl/register_lane.sv | 106 ++++++++++
 rtl/register_bank.sv | 116 +++++++++++
 tb/tb_register_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: per-register op encoding, arithmetic
// mode constants and the priority decoder that turns the op strobes into one op.
package register_bank_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CL   = 3'd1,
    OP_LD   = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SR   = 3'd5,
    OP_SL   = 3'd6
  } op_e;

  localparam logic SAT_WRAP = 1'b0;
  localparam logic SAT_CLIP = 1'b1;

  // Fixed priority: cl > ld > inc > dec > sr > sl.
  function automatic op_e decode_op(input logic cl, input logic ld, input logic inc,
                                    input logic dec, input logic sr, input logic sl);
    op_e op;
    if (cl) begin
      op = OP_CL;
    end else if (ld) begin
      op = OP_LD;
    end else if (inc) begin
      op = OP_INC;
    end else if (dec) begin
      op = OP_DEC;
    end else if (sr) begin
      op = OP_SR;
    end else if (sl) begin
      op = OP_SL;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/register_lane.sv
// One bank register plus its carry flag: executes the decoded op or, when
// rest is high, reloads value and carry from the shadow copy.
module register_lane
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 4,
  parameter int SAT_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  op_e                   op,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  ir,
  input  logic                  il,
  input  logic                  rot,
  input  logic                  rest,
  input  logic [DATA_WIDTH-1:0] rest_value,
  input  logic                  rest_carry,
  output logic [DATA_WIDTH-1:0] value_q,
  output logic                  carry_q
);

  // One spare bit above the wider operand so carry-out and borrow are both visible.
  localparam int   AW   = ((STEP_WIDTH > DATA_WIDTH) ? STEP_WIDTH : DATA_WIDTH) + 1;
  localparam logic MODE = (SAT_MODE != 0) ? SAT_CLIP : SAT_WRAP;

  logic [AW-1:0]         val_ext;
  logic [AW-1:0]         step_ext;
  logic [AW-1:0]         sum;
  logic [AW-1:0]         diff;
  logic                  over;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] value_d;
  logic                  carry_d;

  // Next-state selection for value and carry.
  always_comb begin
    val_ext  = AW'(value_q);
    step_ext = AW'(step);
    sum      = val_ext + step_ext;
    diff     = val_ext - step_ext;
    over     = |sum[AW-1:DATA_WIDTH];
    borrow   = diff[AW-1];
    value_d  = value_q;
    carry_d  = carry_q;
    case (op)
      OP_CL: begin
        value_d = {DATA_WIDTH{1'b0}};
        carry_d = 1'b0;
      end
      OP_LD: begin
        value_d = in_data;
        carry_d = 1'b0;
      end
      OP_INC: begin
        if ((MODE == SAT_CLIP) && over) begin
          value_d = {DATA_WIDTH{1'b1}};
        end else begin
          value_d = sum[DATA_WIDTH-1:0];
        end
        carry_d = over;
      end
      OP_DEC: begin
        if ((MODE == SAT_CLIP) && borrow) begin
          value_d = {DATA_WIDTH{1'b0}};
        end else begin
          value_d = diff[DATA_WIDTH-1:0];
        end
        carry_d = borrow;
      end
      OP_SR: begin
        value_d = {(rot ? value_q[0] : ir), value_q[DATA_WIDTH-1:1]};
        carry_d = value_q[0];
      end
      OP_SL: begin
        value_d = {value_q[DATA_WIDTH-2:0], (rot ? value_q[DATA_WIDTH-1] : il)};
        carry_d = value_q[DATA_WIDTH-1];
      end
      default: begin
        value_d = value_q;
        carry_d = carry_q;
      end
    endcase
    if (rest) begin
      value_d = rest_value;
      carry_d = rest_carry;
    end else begin
      value_d = value_d;
      carry_d = carry_d;
    end
  end

  // Register state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= {DATA_WIDTH{1'b0}};
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS working registers with one op per cycle on the selected lane,
// a whole-bank shadow snapshot/restore and a combinational read port.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_REGS   = 4,
  parameter int  STEP_WIDTH = 4,
  parameter int  SAT_MODE   = 0,
  localparam int SEL_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  cl,
  input  logic                  ld,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  sr,
  input  logic                  ir,
  input  logic                  sl,
  input  logic                  il,
  input  logic                  rot,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  snap,
  input  logic                  rest,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_carry,
  output logic                  rd_zero,
  output logic                  any_carry
);

  op_e                   op_s;
  logic [NUM_REGS-1:0]   sel_onehot;
  op_e                   lane_op      [NUM_REGS];
  logic [DATA_WIDTH-1:0] lane_value   [NUM_REGS];
  logic [NUM_REGS-1:0]   lane_carry;
  logic [DATA_WIDTH-1:0] shadow_value_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] shadow_value_d [NUM_REGS];
  logic [NUM_REGS-1:0]   shadow_carry_q;
  logic [NUM_REGS-1:0]   shadow_carry_d;

  // Op decode and steering; restore silences every per-register op.
  always_comb begin
    op_s = decode_op(cl, ld, inc, dec, sr, sl);
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_onehot[i] = (sel == SEL_W'(i));
      if (sel_onehot[i] && !rest) begin
        lane_op[i] = op_s;
      end else begin
        lane_op[i] = OP_NONE;
      end
    end
  end

  // Snapshot captures pre-edge lane state unless a restore wins this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (snap && !rest) begin
        shadow_value_d[i] = lane_value[i];
      end else begin
        shadow_value_d[i] = shadow_value_q[i];
      end
    end
    if (snap && !rest) begin
      shadow_carry_d = lane_carry;
    end else begin
      shadow_carry_d = shadow_carry_q;
    end
  end

  // Shadow bank storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_value_q[i] <= {DATA_WIDTH{1'b0}};
      end
      shadow_carry_q <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_value_q[i] <= shadow_value_d[i];
      end
      shadow_carry_q <= shadow_carry_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    register_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .STEP_WIDTH (STEP_WIDTH),
      .SAT_MODE   (SAT_MODE)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (lane_op[g]),
      .step       (step),
      .in_data    (in),
      .ir         (ir),
      .il         (il),
      .rot        (rot),
      .rest       (rest),
      .rest_value (shadow_value_q[g]),
      .rest_carry (shadow_carry_q[g]),
      .value_q    (lane_value[g]),
      .carry_q    (lane_carry[g])
    );
  end

  assign rd_data   = lane_value[rd_sel];
  assign rd_carry  = lane_carry[rd_sel];
  assign rd_zero   = (rd_data == {DATA_WIDTH{1'b0}});
  assign any_carry = |lane_carry;

endmodule

// File: tb/tb_register_bank.sv
// Directed vector table plus hand sequences and a randomized model comparison,
// run on a wrap-mode and a saturate-mode instance in parallel.
module tb_register_bank;

  localparam logic [5:0] O_CL  = 6'b100000;
  localparam logic [5:0] O_LD  = 6'b010000;
  localparam logic [5:0] O_INC = 6'b001000;
  localparam logic [5:0] O_DEC = 6'b000100;
  localparam logic [5:0] O_SR  = 6'b000010;
  localparam logic [5:0] O_SL  = 6'b000001;
  localparam logic [5:0] O_NO  = 6'b000000;

  typedef struct {
    logic        rst_n;
    logic [1:0]  sel;
    logic [5:0]  ops;
    logic        ir, il, rot;
    logic [3:0]  step;
    logic [15:0] din;
    logic        snap, rest;
    logic [1:0]  rd_sel;
    logic [15:0] ew;
    logic        cw;
    logic [15:0] es;
    logic        cs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, cl, ld, inc, dec, sr, ir, sl, il, rot, snap, rest;
  logic [1:0]  sel, rd_sel;
  logic [3:0]  step;
  logic [15:0] din;
  logic [15:0] rd_data_o [2];
  logic        rd_carry_o [2];
  logic        rd_zero_o [2];
  logic        any_carry_o [2];

  int checks = 0;
  int failures = 0;

  logic [15:0] m_val [2][4];
  logic        m_c   [2][4];
  logic [15:0] s_val [2][4];
  logic        s_c   [2][4];

  vec_t vecs[$];

  always #5 clk = ~clk;

  register_bank #(.DATA_WIDTH(16), .NUM_REGS(4), .STEP_WIDTH(4), .SAT_MODE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .sel(sel), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .rot(rot), .step(step), .in(din),
    .snap(snap), .rest(rest), .rd_sel(rd_sel), .rd_data(rd_data_o[0]),
    .rd_carry(rd_carry_o[0]), .rd_zero(rd_zero_o[0]), .any_carry(any_carry_o[0]));

  register_bank #(.DATA_WIDTH(16), .NUM_REGS(4), .STEP_WIDTH(4), .SAT_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .sel(sel), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .rot(rot), .step(step), .in(din),
    .snap(snap), .rest(rest), .rd_sel(rd_sel), .rd_data(rd_data_o[1]),
    .rd_carry(rd_carry_o[1]), .rd_zero(rd_zero_o[1]), .any_carry(any_carry_o[1]));

  function automatic vec_t mk(input logic r, input logic [1:0] s, input logic [5:0] o,
                              input logic i_r, input logic i_l, input logic ro,
                              input logic [3:0] st, input logic [15:0] d,
                              input logic sn, input logic re, input logic [1:0] rs,
                              input logic [15:0] ew, input logic cw,
                              input logic [15:0] es, input logic cs);
    vec_t v;
    v.rst_n = r; v.sel = s; v.ops = o; v.ir = i_r; v.il = i_l; v.rot = ro;
    v.step = st; v.din = d; v.snap = sn; v.rest = re; v.rd_sel = rs;
    v.ew = ew; v.cw = cw; v.es = es; v.cs = cs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    rst_n = v.rst_n; sel = v.sel;
    {cl, ld, inc, dec, sr, sl} = v.ops;
    ir = v.ir; il = v.il; rot = v.rot; step = v.step; din = v.din;
    snap = v.snap; rest = v.rest; rd_sel = v.rd_sel;
  endtask

  // Reference behaviour, written from the register-level description.
  task automatic model_step();
    int v, t, nv, nc;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          m_val[m][k] = 16'h0; m_c[m][k] = 1'b0; s_val[m][k] = 16'h0; s_c[m][k] = 1'b0;
        end
      end else if (rest) begin
        for (int k = 0; k < 4; k++) begin
          m_val[m][k] = s_val[m][k]; m_c[m][k] = s_c[m][k];
        end
      end else begin
        if (snap) begin
          for (int k = 0; k < 4; k++) begin
            s_val[m][k] = m_val[m][k]; s_c[m][k] = m_c[m][k];
          end
        end
        v = int'(m_val[m][sel]);
        if (cl) begin
          nv = 0; nc = 0;
        end else if (ld) begin
          nv = int'(din); nc = 0;
        end else if (inc) begin
          t = v + int'(step);
          nc = (t > 65535) ? 1 : 0;
          nv = (m == 1 && t > 65535) ? 65535 : t % 65536;
        end else if (dec) begin
          t = v - int'(step);
          nc = (t < 0) ? 1 : 0;
          nv = (m == 1 && t < 0) ? 0 : (t + 65536) % 65536;
        end else if (sr) begin
          nc = v % 2;
          nv = v / 2 + (rot ? v % 2 : int'(ir)) * 32768;
        end else if (sl) begin
          nc = v / 32768;
          nv = (v * 2) % 65536 + (rot ? v / 32768 : int'(il));
        end else begin
          nv = v; nc = int'(m_c[m][sel]);
        end
        m_val[m][sel] = nv[15:0];
        m_c[m][sel]   = nc[0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [15:0] ed;
    logic        ec;
    logic        oc;
    set_in(mk(1'b0, 2'd0, O_NO, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0));
    #1;

    vecs.push_back(mk(0, 0, O_NO,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, O_LD,  0, 0, 0, 4'd0, 16'h1111, 0, 0, 0, 16'h1111, 0, 16'h1111, 0));
    vecs.push_back(mk(1, 1, O_LD,  0, 0, 0, 4'd0, 16'h2222, 0, 0, 1, 16'h2222, 0, 16'h2222, 0));
    vecs.push_back(mk(0, 0, O_INC, 0, 0, 0, 4'd1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, O_NO,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, O_NO,  0, 0, 0, 4'd0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, O_CL | O_LD | O_INC, 0, 0, 0, 4'd1, 16'h1234, 0, 0, 1, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 2, O_LD,  0, 0, 0, 4'd0, 16'hFFFE, 0, 0, 2, 16'hFFFE, 0, 16'hFFFE, 0));
    vecs.push_back(mk(1, 2, O_INC, 0, 0, 0, 4'd3, 16'h0000, 0, 0, 2, 16'h0001, 1, 16'hFFFF, 1));
    vecs.push_back(mk(1, 3, O_LD,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 3, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 3, O_DEC, 0, 0, 0, 4'd1, 16'h0000, 0, 0, 3, 16'hFFFF, 1, 16'h0000, 1));
    vecs.push_back(mk(1, 3, O_INC, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 3, 16'hFFFF, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 2, O_LD,  0, 0, 0, 4'd0, 16'h0010, 0, 0, 2, 16'h0010, 0, 16'h0010, 0));
    vecs.push_back(mk(1, 2, O_INC, 0, 0, 0, 4'd5, 16'h0000, 0, 0, 2, 16'h0015, 0, 16'h0015, 0));
    vecs.push_back(mk(1, 2, O_DEC, 0, 0, 0, 4'hF, 16'h0000, 0, 0, 2, 16'h0006, 0, 16'h0006, 0));
    vecs.push_back(mk(1, 0, O_LD,  0, 0, 0, 4'd0, 16'h8001, 0, 0, 0, 16'h8001, 0, 16'h8001, 0));
    vecs.push_back(mk(1, 0, O_SR,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 16'h4000, 1, 16'h4000, 1));
    vecs.push_back(mk(1, 0, O_LD,  0, 0, 0, 4'd0, 16'h8001, 0, 0, 0, 16'h8001, 0, 16'h8001, 0));
    vecs.push_back(mk(1, 0, O_SR,  0, 0, 1, 4'd0, 16'h0000, 0, 0, 0, 16'hC000, 1, 16'hC000, 1));
    vecs.push_back(mk(1, 0, O_LD,  0, 0, 0, 4'd0, 16'h8001, 0, 0, 0, 16'h8001, 0, 16'h8001, 0));
    vecs.push_back(mk(1, 0, O_SL,  0, 1, 0, 4'd0, 16'h0000, 0, 0, 0, 16'h0003, 1, 16'h0003, 1));
    vecs.push_back(mk(1, 0, O_SL,  0, 0, 1, 4'd0, 16'h0000, 0, 0, 0, 16'h0006, 0, 16'h0006, 0));
    vecs.push_back(mk(1, 0, O_SR,  1, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 16'h8003, 0, 16'h8003, 0));
    vecs.push_back(mk(1, 0, O_SL,  0, 0, 1, 4'd0, 16'h0000, 0, 0, 0, 16'h0007, 1, 16'h0007, 1));
    vecs.push_back(mk(1, 0, O_DEC | O_SR, 0, 0, 0, 4'd1, 16'h0000, 0, 0, 0, 16'h0006, 0, 16'h0006, 0));
    vecs.push_back(mk(1, 0, O_INC | O_DEC, 0, 0, 0, 4'd2, 16'h0000, 0, 0, 0, 16'h0008, 0, 16'h0008, 0));
    vecs.push_back(mk(1, 0, O_SR | O_SL, 0, 1, 0, 4'd0, 16'h0000, 0, 0, 0, 16'h0004, 0, 16'h0004, 0));
    vecs.push_back(mk(1, 0, O_LD,  0, 0, 0, 4'd0, 16'h0001, 0, 0, 0, 16'h0001, 0, 16'h0001, 0));
    vecs.push_back(mk(1, 1, O_LD,  0, 0, 0, 4'd0, 16'h0002, 0, 0, 1, 16'h0002, 0, 16'h0002, 0));
    vecs.push_back(mk(1, 2, O_LD,  0, 0, 0, 4'd0, 16'h0003, 0, 0, 2, 16'h0003, 0, 16'h0003, 0));
    vecs.push_back(mk(1, 3, O_LD,  0, 0, 0, 4'd0, 16'hFFFF, 0, 0, 3, 16'hFFFF, 0, 16'hFFFF, 0));
    vecs.push_back(mk(1, 3, O_INC, 0, 0, 0, 4'd5, 16'h0000, 0, 0, 3, 16'h0004, 1, 16'hFFFF, 1));
    vecs.push_back(mk(1, 0, O_LD,  0, 0, 0, 4'd0, 16'h0009, 1, 0, 0, 16'h0009, 0, 16'h0009, 0));
    vecs.push_back(mk(1, 3, O_LD,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 3, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 2, O_LD,  0, 0, 0, 4'd0, 16'h0007, 0, 1, 3, 16'h0004, 1, 16'hFFFF, 1));
    vecs.push_back(mk(1, 0, O_NO,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 16'h0001, 0, 16'h0001, 0));
    vecs.push_back(mk(1, 0, O_NO,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 2, 16'h0003, 0, 16'h0003, 0));
    vecs.push_back(mk(1, 0, O_NO,  0, 0, 0, 4'd0, 16'h0000, 0, 0, 1, 16'h0002, 0, 16'h0002, 0));

    foreach (vecs[i]) begin
      set_in(vecs[i]);
      tick();
      for (int m = 0; m < 2; m++) begin
        ed = (m == 0) ? vecs[i].ew : vecs[i].es;
        ec = (m == 0) ? vecs[i].cw : vecs[i].cs;
        chk($sformatf("vec%0d_m%0d_data", i, m), 32'(rd_data_o[m]), 32'(ed));
        chk($sformatf("vec%0d_m%0d_carry", i, m), 32'(rd_carry_o[m]), 32'(ec));
        chk($sformatf("vec%0d_m%0d_zero", i, m), 32'(rd_zero_o[m]), 32'(ed == 16'h0000));
      end
    end

    // Reset pulse that never spans a rising edge must leave state alone.
    set_in(mk(1, 2, O_LD, 0, 0, 0, 4'd0, 16'h5555, 0, 0, 2, 16'h0, 0, 16'h0, 0));
    tick();
    set_in(mk(1, 0, O_NO, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 2, 16'h0, 0, 16'h0, 0));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("glitch_rst_m%0d", m), 32'(rd_data_o[m]), 32'h5555);
    end

    // No write-to-read bypass: load is invisible until after the edge.
    set_in(mk(1, 1, O_LD, 0, 0, 0, 4'd0, 16'hABCD, 0, 0, 1, 16'h0, 0, 16'h0, 0));
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("no_bypass_pre_m%0d", m), 32'(rd_data_o[m]), 32'h0002);
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("no_bypass_post_m%0d", m), 32'(rd_data_o[m]), 32'hABCD);
    end

    for (int n = 0; n < 400; n++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      sel    = 2'($urandom_range(0, 3));
      cl     = ($urandom_range(0, 5) == 0);
      ld     = ($urandom_range(0, 4) == 0);
      inc    = ($urandom_range(0, 2) == 0);
      dec    = ($urandom_range(0, 2) == 0);
      sr     = ($urandom_range(0, 2) == 0);
      sl     = ($urandom_range(0, 2) == 0);
      ir     = 1'($urandom_range(0, 1));
      il     = 1'($urandom_range(0, 1));
      rot    = 1'($urandom_range(0, 1));
      step   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       din = 16'($urandom_range(0, 65535));
        1:       din = 16'hFFF0 | 16'($urandom_range(0, 15));
        default: din = 16'($urandom_range(0, 15));
      endcase
      snap   = ($urandom_range(0, 7) == 0);
      rest   = ($urandom_range(0, 11) == 0);
      rd_sel = 2'($urandom_range(0, 3));
      tick();
      for (int m = 0; m < 2; m++) begin
        oc = m_c[m][0] | m_c[m][1] | m_c[m][2] | m_c[m][3];
        chk($sformatf("rnd%0d_m%0d_data", n, m), 32'(rd_data_o[m]), 32'(m_val[m][rd_sel]));
        chk($sformatf("rnd%0d_m%0d_carry", n, m), 32'(rd_carry_o[m]), 32'(m_c[m][rd_sel]));
        chk($sformatf("rnd%0d_m%0d_zero", n, m), 32'(rd_zero_o[m]), 32'(m_val[m][rd_sel] == 16'h0000));
        chk($sformatf("rnd%0d_m%0d_anyc", n, m), 32'(any_carry_o[m]), 32'(oc));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
